btn_press_classifier: RTL and testbench
=======================================

// Module: btn_press_classifier
// PURPOSE
//  Downstream of the button debouncer: consumes the clean, debounced button level and
//  classifies each gesture as a short press, long press or double press. One single-cycle
//  pulse per gesture, plus a saturating press counter. Feeds menu/mode control logic.
// PARAMETERS
//  LONG_CYC  16  consecutive high samples that make a long press (>=2)
//  DBL_GAP    8  consecutive low samples after a short press that close the gesture (>=2)
//  CNT_W      8  width of press_count
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high; sole reset
//  btn_db        in   1      debounced button level, 1 = pressed, synchronous to clk
//  clr_count     in   1      synchronous clear of press_count
//  short_press   out  1      1-cycle pulse: single press released, no second press in time
//  long_press    out  1      1-cycle pulse: held LONG_CYC samples
//  double_press  out  1      1-cycle pulse: second press released within the gap window
//  press_count   out  CNT_W  number of accepted press edges, saturating
//  busy          out  1      1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, timer=0, all pulses 0, press_count=0, busy=0. Reset beats every input.
//  - All outputs registered. Each pulse is high exactly the one cycle after the deciding edge.
//  - Timer width = $clog2(max(LONG_CYC,DBL_GAP)+1). Timer counts samples in the current state.
//  - FSM (values sampled at each rising edge):
//    IDLE:      btn_db=1 -> PRESSED, timer<=1, count++.
//    PRESSED:   btn_db=0 -> GAP, timer<=1.
//               btn_db=1 and timer==LONG_CYC-1 -> LONG_HELD, long_press<=1.
//               else timer++.
//    LONG_HELD: btn_db=0 -> IDLE. Emits no further pulse; short/double never follow a long.
//    GAP:       btn_db=1 -> SECOND, count++.
//               btn_db=0 and timer==DBL_GAP-1 -> IDLE, short_press<=1.
//               else timer++.
//    SECOND:    btn_db=0 -> IDLE, double_press<=1. Hold length in SECOND is ignored;
//               a long second press still yields double_press on release.
//  - Net timing: long_press after LONG_CYC consecutive highs. short_press after DBL_GAP
//    consecutive lows following a press of <LONG_CYC highs. A press on low sample
//    DBL_GAP+1 or later starts a new gesture.
//  - At most one pulse is high in any cycle. The pulses are mutually exclusive per gesture.
//  - press_count: +1 on IDLE->PRESSED and on GAP->SECOND. Holds at 2^CNT_W-1 and does not wrap.
//    clr_count=1 forces 0 and has priority over a same-cycle increment.
//  - Reset mid-gesture aborts it silently: no pulse. The next high sample starts from IDLE.
//  - btn_db already high when reset releases counts as a press on the first sampled edge.
// TESTING (LONG_CYC=16, DBL_GAP=8, CNT_W=8 unless noted)
//  1. btn_db high 5 cyc, then low -> short_press 1 cyc after the 8th low sample.
//     No long or double pulse. press_count=1.
//  2. btn_db high 20 cyc -> long_press 1 cyc after the 16th high sample, once. Then release
//     and hold low 20 -> no short_press. busy=0 after release. press_count=1.
//  3. high 4, low 3, high 4, low -> double_press 1 cyc after the first low of the second press.
//     No short_press. press_count=2.
//  4. Gap boundary: high 3, low 8, high 3, low -> short_press after the 8th low, then a second
//     short_press for the new gesture. With low 7 instead -> a single double_press.
//  5. CNT_W=2: seven separated short presses -> press_count 1,2,3,3,3,3,3.
//     clr_count in the same cycle as an IDLE->PRESSED edge -> press_count=0.
//  6. reset at PRESSED timer=10, then at GAP timer=5, then in SECOND -> no pulse each time.
//     All outputs 0 the cycle after reset. A subsequent 5-high press classifies normally.

Source files
------------

// File: rtl/btn_press_classifier.sv
// btn_press_classifier
// Classifies debounced button gestures into short, long and double presses.
// Each gesture produces exactly one single-cycle pulse; a saturating counter
// tallies accepted press edges (the initial press and a second press in the
// gap window). All outputs are registered.

module btn_press_classifier #(
    parameter int LONG_CYC = 16,
    parameter int DBL_GAP  = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_db,
    input  logic             clr_count,
    output logic             short_press,
    output logic             long_press,
    output logic             double_press,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    // Timer must hold the largest terminal value of either window.
    localparam int MAX_CYC = (LONG_CYC > DBL_GAP) ? LONG_CYC : DBL_GAP;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]    TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0]    LONG_LAST  = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0]    GAP_LAST   = TW'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_GAP       = 3'd3,
        ST_SECOND    = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_s;
    logic            short_s;
    logic            long_s;
    logic            double_s;
    logic            inc_s;
    logic            busy_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Next-state, timer and pulse decode for the gesture FSM.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        short_s  = 1'b0;
        long_s   = 1'b0;
        double_s = 1'b0;
        inc_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (btn_db) begin
                    state_s = ST_PRESSED;
                    timer_s = TIMER_ONE;
                    inc_s   = 1'b1;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end

            ST_PRESSED: begin
                if (!btn_db) begin
                    state_s = ST_GAP;
                    timer_s = TIMER_ONE;
                end else if (timer_r == LONG_LAST) begin
                    state_s = ST_LONG_HELD;
                    timer_s = TIMER_ZERO;
                    long_s  = 1'b1;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end

            ST_LONG_HELD: begin
                // A long press owns the whole gesture; release just returns home.
                if (!btn_db) begin
                    state_s = ST_IDLE;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end

            ST_GAP: begin
                if (btn_db) begin
                    state_s = ST_SECOND;
                    timer_s = TIMER_ZERO;
                    inc_s   = 1'b1;
                end else if (timer_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    timer_s = TIMER_ZERO;
                    short_s = 1'b1;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end

            ST_SECOND: begin
                // Hold length of the second press is irrelevant.
                if (!btn_db) begin
                    state_s  = ST_IDLE;
                    timer_s  = TIMER_ZERO;
                    double_s = 1'b1;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end

            default: begin
                state_s = ST_IDLE;
                timer_s = TIMER_ZERO;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // FSM state and timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= TIMER_ZERO;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
        end
    end

    // Registered pulse and busy outputs; busy tracks the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= short_s;
            long_press   <= long_s;
            double_press <= double_s;
            busy         <= busy_s;
        end
    end

    // Press counter: clear wins over a same-cycle increment; saturates at max.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= CNT_ZERO;
        end else if (clr_count) begin
            press_count <= CNT_ZERO;
        end else if (inc_s) begin
            press_count <= sat_inc(press_count);
        end else begin
            press_count <= press_count;
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed testbench for btn_press_classifier: a default-width instance and a
// CNT_W=2 instance share all stimulus; expected values are hand-derived.

module tb_btn_press_classifier;

    logic       clk;
    logic       reset;
    logic       btn_db;
    logic       clr_count;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic [7:0] press_count;
    logic       busy;
    logic       short_press2;
    logic       long_press2;
    logic       double_press2;
    logic [1:0] press_count2;
    logic       busy2;

    int tests_run;
    int tests_failed;
    int sp_cnt;
    int lp_cnt;
    int dp_cnt;

    btn_press_classifier #(.LONG_CYC(16), .DBL_GAP(8), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_db       (btn_db),
        .clr_count    (clr_count),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .press_count  (press_count),
        .busy         (busy)
    );

    btn_press_classifier #(.LONG_CYC(16), .DBL_GAP(8), .CNT_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .btn_db       (btn_db),
        .clr_count    (clr_count),
        .short_press  (short_press2),
        .long_press   (long_press2),
        .double_press (double_press2),
        .press_count  (press_count2),
        .busy         (busy2)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tallies();
        sp_cnt = 0;
        lp_cnt = 0;
        dp_cnt = 0;
    endtask

    // Apply a level for n samples, tallying pulses and checking exclusivity.
    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            btn_db = lvl;
            step();
            sp_cnt += int'(short_press);
            lp_cnt += int'(long_press);
            dp_cnt += int'(double_press);
            check("pulse_excl", 32'(int'(short_press) + int'(long_press) + int'(double_press) <= 1), 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_short"},  32'(short_press),  32'd0);
        check({tag, "_long"},   32'(long_press),   32'd0);
        check({tag, "_double"}, 32'(double_press), 32'd0);
        check({tag, "_count"},  32'(press_count),  32'd0);
        check({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    task automatic do_reset(input logic btn_during);
        reset  = 1'b1;
        btn_db = btn_during;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        clear_tallies();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        btn_db       = 1'b0;
        clr_count    = 1'b0;
        clear_tallies();

        // Test 1: short press.
        do_reset(1'b0);
        drive(1'b1, 5);
        check("t1_busy_pressed", 32'(busy), 32'd1);
        drive(1'b0, 7);
        check("t1_short_early", 32'(short_press), 32'd0);
        drive(1'b0, 1);
        check("t1_short", 32'(short_press), 32'd1);
        check("t1_busy_idle", 32'(busy), 32'd0);
        drive(1'b0, 1);
        check("t1_short_one_cycle", 32'(short_press), 32'd0);
        check("t1_sp_cnt", 32'(sp_cnt), 32'd1);
        check("t1_lp_cnt", 32'(lp_cnt), 32'd0);
        check("t1_dp_cnt", 32'(dp_cnt), 32'd0);
        check("t1_count", 32'(press_count), 32'd1);

        // Test 2: long press, release produces nothing more.
        do_reset(1'b0);
        drive(1'b1, 15);
        check("t2_long_early", 32'(long_press), 32'd0);
        drive(1'b1, 1);
        check("t2_long", 32'(long_press), 32'd1);
        drive(1'b1, 4);
        check("t2_lp_cnt", 32'(lp_cnt), 32'd1);
        check("t2_busy_held", 32'(busy), 32'd1);
        drive(1'b0, 1);
        check("t2_busy_release", 32'(busy), 32'd0);
        drive(1'b0, 20);
        check("t2_sp_cnt", 32'(sp_cnt), 32'd0);
        check("t2_dp_cnt", 32'(dp_cnt), 32'd0);
        check("t2_count", 32'(press_count), 32'd1);

        // Test 3: double press.
        do_reset(1'b0);
        drive(1'b1, 4);
        drive(1'b0, 3);
        drive(1'b1, 4);
        check("t3_count", 32'(press_count), 32'd2);
        check("t3_double_early", 32'(double_press), 32'd0);
        drive(1'b0, 1);
        check("t3_double", 32'(double_press), 32'd1);
        drive(1'b0, 10);
        check("t3_dp_cnt", 32'(dp_cnt), 32'd1);
        check("t3_sp_cnt", 32'(sp_cnt), 32'd0);
        check("t3_lp_cnt", 32'(lp_cnt), 32'd0);

        // Test 4a: press on low sample 9 starts a new gesture.
        do_reset(1'b0);
        drive(1'b1, 3);
        drive(1'b0, 8);
        check("t4a_short1", 32'(short_press), 32'd1);
        drive(1'b1, 3);
        drive(1'b0, 8);
        check("t4a_short2", 32'(short_press), 32'd1);
        check("t4a_sp_cnt", 32'(sp_cnt), 32'd2);
        check("t4a_dp_cnt", 32'(dp_cnt), 32'd0);
        check("t4a_count", 32'(press_count), 32'd2);

        // Test 4b: press on low sample 8 is still a double.
        do_reset(1'b0);
        drive(1'b1, 3);
        drive(1'b0, 7);
        drive(1'b1, 3);
        drive(1'b0, 1);
        check("t4b_double", 32'(double_press), 32'd1);
        drive(1'b0, 10);
        check("t4b_sp_cnt", 32'(sp_cnt), 32'd0);
        check("t4b_dp_cnt", 32'(dp_cnt), 32'd1);

        // Test 5: saturation on the 2-bit instance, then clear beats increment.
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 2);
            check("t5_count_sat", 32'(press_count2), 32'((i + 1 < 3) ? i + 1 : 3));
            drive(1'b0, 9);
        end
        check("t5_count_wide", 32'(press_count), 32'd7);
        check("t5_sp_cnt", 32'(sp_cnt), 32'd7);
        clr_count = 1'b1;
        drive(1'b1, 1);
        check("t5_clr_count2", 32'(press_count2), 32'd0);
        check("t5_clr_count", 32'(press_count), 32'd0);
        check("t5_clr_busy", 32'(busy), 32'd1);
        clr_count = 1'b0;
        drive(1'b0, 9);

        // Test 6: reset aborts gestures in PRESSED, GAP and SECOND silently.
        do_reset(1'b0);
        drive(1'b1, 10);
        do_reset(1'b1);
        drive(1'b0, 3);
        check("t6_no_pulse_a", 32'(sp_cnt + lp_cnt + dp_cnt), 32'd0);
        clear_tallies();
        drive(1'b1, 3);
        drive(1'b0, 5);
        do_reset(1'b0);
        drive(1'b0, 10);
        check("t6_no_pulse_b", 32'(sp_cnt + lp_cnt + dp_cnt), 32'd0);
        clear_tallies();
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 3);
        // Button still held across reset release: first sampled edge is a press.
        do_reset(1'b1);
        drive(1'b1, 1);
        check("t6_press_at_release", 32'(press_count), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        drive(1'b1, 4);
        drive(1'b0, 8);
        check("t6_short", 32'(short_press), 32'd1);
        check("t6_sp_cnt", 32'(sp_cnt), 32'd1);
        check("t6_dp_cnt", 32'(dp_cnt), 32'd0);
        check("t6_count", 32'(press_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
